bcd_subtractor_seq: RTL
=======================

BCD_SUBTRACTOR_SEQ -- requirements
Module: bcd_subtractor_seq

Interface
REQ-001 Parameter: DIGITS, default 4, number of packed BCD digits per operand (legal range 1..8).
REQ-002 Port: clk  input  1  the single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on rising clk.
REQ-005 Port: a  input  4*DIGITS  minuend, packed BCD, digit 0 in bits [3:0].
REQ-006 Port: b  input  4*DIGITS  subtrahend, same packing as a.
REQ-007 Port: busy  output  1  high while an operation is in progress.
REQ-008 Port: done  output  1  one-cycle pulse when results are valid.
REQ-009 Port: diff  output  4*DIGITS  magnitude |a-b|, packed BCD.
REQ-010 Port: neg  output  1  high when a < b.
REQ-011 Port: invalid  output  1  high when any digit of a or b was above 9.

Function
REQ-012 The block SHALL accept start only in state IDLE; start during busy SHALL be ignored.
REQ-013 On the accepting edge (edge 0), the block SHALL latch a and b, clear the internal borrow, and set busy.
REQ-014 If any latched digit exceeds 9, the block SHALL go to DONE: done=1 and invalid=1 at edge 1, with diff=0 and neg=0.
REQ-015 States: IDLE, SUB, NEG, DONE; flow IDLE->SUB->(NEG if final borrow)->DONE->IDLE. DONE SHALL last exactly one cycle.
REQ-016 In SUB, one digit SHALL be processed per edge, least significant digit first; digit k is processed at edge k+1.
REQ-017 Digit rule: t = a_k - b_k - borrow. If t < 0, result digit = t+10 and borrow=1; otherwise result digit = t and borrow=0.
REQ-018 If borrow=0 after the last digit, the block SHALL enter DONE with neg=0; done rises at edge DIGITS.
REQ-019 If borrow=1 after the last digit, the block SHALL run NEG.
    - NEG applies the REQ-017 rule to 0 minus the intermediate result, one digit per edge, borrow cleared at NEG entry.
    - This produces the ten's-complement magnitude.
    - neg=1 is set; done rises at edge 2*DIGITS.
REQ-020 Each result digit SHALL be a legal BCD digit (0..9).
REQ-021 Equal operands SHALL yield diff=0 and neg=0.
REQ-022 busy SHALL fall on the same edge that done rises.
REQ-023 diff, neg and invalid SHALL hold their values after done until the next accepted start.
    - Between that start and the next done, their values are don't-care.
REQ-024 start high in the DONE cycle SHALL be ignored; start is accepted from the following IDLE cycle.
REQ-025 No combinational path SHALL exist from any input to any output; all outputs are registered.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, without waiting for clk:
    - force state=IDLE;
    - set busy=0, done=0, diff=0, neg=0, invalid=0;
    - clear borrow, the digit index, and the latched operands.
REQ-027 Reset asserted mid-operation SHALL abort the operation; no done pulse SHALL follow for it.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (DIGITS=4)
REQ-029 a=0x0123, b=0x0045, start pulse -> done at edge 4, diff=0x0078, neg=0, invalid=0, busy high edges 0..3.
REQ-030 a=0x0045, b=0x0123 -> done at edge 8, diff=0x0078, neg=1.
REQ-031 Wrap and zero cases:
    - a=0x0000, b=0x9999 -> diff=0x9999, neg=1.
    - a=0x9999, b=0x9999 -> diff=0x0000, neg=0, done at edge 4.
REQ-032 a=0x00A0, b=0x0001 -> done at edge 1, invalid=1, diff=0x0000, neg=0.
REQ-033 Start and reset corner cases:
    - Start re-pulsed at edges 1-3 of an operation -> ignored; single done, result unchanged.
    - rst_n low at edge 2 -> all outputs 0 immediately; no done.
    - A fresh start after release completes normally.

Source files
------------

// File: rtl/bcd_subtractor_seq.sv
// -----------------------------------------------------------------------------
// bcd_subtractor_seq
//
// Sequential packed-BCD subtractor. It produces |a - b| one digit per clock,
// least significant digit first. If the raw subtraction ends with a borrow,
// the intermediate result is a ten's complement. A second pass then computes
// 0 minus that result, which turns it back into a magnitude, and neg is set.
// If any operand digit is above 9, the operation stops after one edge with
// invalid set.
//
// Ports
//   clk      : clock, all state changes on the rising edge
//   rst_n    : asynchronous active-low reset
//   start    : begin a subtraction; accepted only when idle
//   a, b     : minuend / subtrahend, packed BCD, digit 0 in bits [3:0]
//   busy     : high while an operation is in progress
//   done     : one-cycle pulse when diff/neg/invalid are valid
//   diff     : magnitude |a-b|, packed BCD
//   neg      : a < b
//   invalid  : an operand digit was above 9 (diff and neg are then 0)
// -----------------------------------------------------------------------------
module bcd_subtractor_seq #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  neg,
   output logic                  invalid
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          state_reg,   state_next;
   logic [W-1:0]    a_reg,       a_next;
   logic [W-1:0]    b_reg,       b_next;
   logic [W-1:0]    diff_reg,    diff_next;
   logic [IW-1:0]   idx_reg,     idx_next;
   logic            borrow_reg,  borrow_next;
   logic            busy_reg,    busy_next;
   logic            done_reg,    done_next;
   logic            neg_reg,     neg_next;
   logic            invalid_reg, invalid_next;

   // Detect digits above 9 in the latched operands.
   logic [DIGITS-1:0] digit_bad;
   logic              any_bad;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_chk
         assign digit_bad[gi] = (a_reg[gi*4 +: 4] > 4'd9) || (b_reg[gi*4 +: 4] > 4'd9);
      end
   endgenerate

   assign any_bad = |digit_bad;

   // Single-digit borrow subtractor shared by SUB and NEG.
   // In SUB it computes a_k - b_k. In NEG it computes 0 - diff_k, using the
   // intermediate result held in diff_reg.
   logic [3:0] op_x, op_y, dig_res;
   logic [4:0] dig_t;
   logic       dig_borrow;
   logic       last_digit;

   always_comb begin
      op_x = 4'd0;
      op_y = 4'd0;
      if (state_reg == SUB) begin
         op_x = a_reg[int'(idx_reg)*4 +: 4];
         op_y = b_reg[int'(idx_reg)*4 +: 4];
      end else begin
         op_y = diff_reg[int'(idx_reg)*4 +: 4];
      end
      // dig_t is a 5-bit two's complement value in the range -10..9.
      dig_t      = {1'b0, op_x} - {1'b0, op_y} - {4'd0, borrow_reg};
      dig_borrow = dig_t[4];
      // Adding 10 modulo 16 maps the range -10..-1 onto 0..9.
      dig_res    = dig_t[4] ? (dig_t[3:0] + 4'd10) : dig_t[3:0];
   end

   assign last_digit = (idx_reg == IW'(DIGITS - 1));

   // Next-state and output logic.
   always_comb begin
      state_next   = state_reg;
      a_next       = a_reg;
      b_next       = b_reg;
      diff_next    = diff_reg;
      idx_next     = idx_reg;
      borrow_next  = borrow_reg;
      busy_next    = busy_reg;
      done_next    = 1'b0;
      neg_next     = neg_reg;
      invalid_next = invalid_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next       = a;
               b_next       = b;
               diff_next    = '0;
               idx_next     = '0;
               borrow_next  = 1'b0;
               busy_next    = 1'b1;
               neg_next     = 1'b0;
               invalid_next = 1'b0;
               state_next   = SUB;
            end
         end

         SUB: begin
            if (any_bad) begin
               diff_next    = '0;
               neg_next     = 1'b0;
               invalid_next = 1'b1;
               done_next    = 1'b1;
               busy_next    = 1'b0;
               state_next   = DONE;
            end else begin
               diff_next[int'(idx_reg)*4 +: 4] = dig_res;
               borrow_next = dig_borrow;
               idx_next    = idx_reg + IW'(1);
               if (last_digit) begin
                  if (dig_borrow) begin
                     // The raw result is a ten's complement. Start the
                     // negation pass from digit 0 with the borrow cleared.
                     idx_next    = '0;
                     borrow_next = 1'b0;
                     state_next  = NEG;
                  end else begin
                     neg_next   = 1'b0;
                     done_next  = 1'b1;
                     busy_next  = 1'b0;
                     state_next = DONE;
                  end
               end
            end
         end

         NEG: begin
            diff_next[int'(idx_reg)*4 +: 4] = dig_res;
            borrow_next = dig_borrow;
            idx_next    = idx_reg + IW'(1);
            if (last_digit) begin
               neg_next   = 1'b1;
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = DONE;
            end
         end

         DONE: begin
            // start is ignored for this one cycle.
            state_next = IDLE;
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         diff_reg    <= '0;
         idx_reg     <= '0;
         borrow_reg  <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
         neg_reg     <= 1'b0;
         invalid_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         a_reg       <= a_next;
         b_reg       <= b_next;
         diff_reg    <= diff_next;
         idx_reg     <= idx_next;
         borrow_reg  <= borrow_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         neg_reg     <= neg_next;
         invalid_reg <= invalid_next;
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign diff    = diff_reg;
   assign neg     = neg_reg;
   assign invalid = invalid_reg;

endmodule
